// File: rtl/fm_fft_pkg.sv
// Shared constants and types for the FM FFT feeder path.
// Sample words are {real, imag}; the Avalon-ST error code is passed as a constant.
package fm_fft_pkg;

    localparam int DATA_W  = 22;
    localparam int FFT_LEN = 1024;
    localparam int SINK_W  = 2 * DATA_W;

    localparam int RE_LSB = DATA_W;
    localparam int RE_MSB = SINK_W - 1;
    localparam int IM_LSB = 0;
    localparam int IM_MSB = DATA_W - 1;

    localparam logic [1:0] AVST_ERR_NONE     = 2'b00;
    localparam logic [1:0] AVST_ERR_OVERFLOW = 2'b01;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_feed_fifo.sv
// Show-ahead synchronous FIFO; a push is visible on dout one cycle later.
// Full rejects a push unless a pop happens in the same cycle.
module fft_feed_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers free-running samples and frames them into FFT_LEN-word Avalon-ST packets.
// One cycle input-to-valid latency; FFT backpressure fills the FIFO, then samples drop and overflow sticks.
module fft_frame_feeder #(
    parameter int FFT_LEN    = 1024,
    parameter int DATA_W     = 22,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_i,
    input  logic [DATA_W-1:0]   in_q,
    output logic                fft_sink_valid,
    input  logic                fft_sink_ready,
    output logic [1:0]          fft_sink_error,
    output logic                fft_sink_startofpacket,
    output logic                fft_sink_endofpacket,
    output logic [2*DATA_W-1:0] fft_sink_data,
    output logic                overflow,
    input  logic                clear_overflow,
    output logic [15:0]         frame_count
);

    import fm_fft_pkg::*;

    localparam int IDX_W = $clog2(FFT_LEN);

    cplx_t              in_word;
    logic               fifo_full, fifo_empty;
    logic               xfer, push, drop, idx_last;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               ovf_q, ovf_d;

    assign in_word.re = in_i;
    assign in_word.im = in_q;

    assign xfer     = fft_sink_valid && fft_sink_ready;
    assign push     = in_valid && (!fifo_full || xfer);
    assign drop     = in_valid && fifo_full && !xfer;
    assign idx_last = (idx_q == IDX_W'(FFT_LEN - 1));

    fft_feed_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_ni  (reset_reset_n),
        .push_i  (push),
        .pop_i   (xfer),
        .din_i   (in_word),
        .dout_o  (fft_sink_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fft_sink_valid         = !fifo_empty;
    assign fft_sink_error         = AVST_ERR_NONE;
    assign fft_sink_startofpacket = (idx_q == '0) && fft_sink_valid;
    assign fft_sink_endofpacket   = idx_last && fft_sink_valid;
    assign overflow               = ovf_q;
    assign frame_count            = frame_cnt_q;

    always_comb begin
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        if (xfer) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
            if (idx_last) frame_cnt_d = frame_cnt_q + 1'b1;
        end
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            idx_q       <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Randomised bench for fft_frame_feeder with FFT_LEN=8, FIFO_DEPTH=16.
// Reference is a queue of words plus a frame position counter.
module tb_fft_frame_feeder;

    localparam int LEN   = 8;
    localparam int DEPTH = 16;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        in_valid;
    logic [21:0] in_i, in_q;
    logic        fft_sink_valid;
    logic        fft_sink_ready;
    logic [1:0]  fft_sink_error;
    logic        fft_sink_startofpacket;
    logic        fft_sink_endofpacket;
    logic [43:0] fft_sink_data;
    logic        overflow;
    logic        clear_overflow;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;

    logic [43:0] mq[$];
    int          mpos;
    int          mframes;
    bit          movf;

    fft_frame_feeder #(.FFT_LEN(LEN), .DATA_W(22), .FIFO_DEPTH(DEPTH)) dut (
        .clk_clk                (clk_clk),
        .reset_reset_n          (reset_reset_n),
        .in_valid               (in_valid),
        .in_i                   (in_i),
        .in_q                   (in_q),
        .fft_sink_valid         (fft_sink_valid),
        .fft_sink_ready         (fft_sink_ready),
        .fft_sink_error         (fft_sink_error),
        .fft_sink_startofpacket (fft_sink_startofpacket),
        .fft_sink_endofpacket   (fft_sink_endofpacket),
        .fft_sink_data          (fft_sink_data),
        .overflow               (overflow),
        .clear_overflow         (clear_overflow),
        .frame_count            (frame_count)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_step();
        bit v, x, full, drop;
        logic [43:0] w;
        w    = {in_i, in_q};
        v    = (mq.size() != 0);
        x    = v && fft_sink_ready;
        full = (mq.size() == DEPTH);
        drop = in_valid && full && !x;
        if (x) begin
            void'(mq.pop_front());
            if (mpos == LEN - 1) begin
                mpos = 0;
                mframes = (mframes + 1) % 65536;
            end else begin
                mpos++;
            end
        end
        if (in_valid && !drop) mq.push_back(w);
        if (drop) movf = 1'b1;
        else if (clear_overflow) movf = 1'b0;
    endtask

    task automatic apply_reset();
        reset_reset_n  = 1'b0;
        in_valid       = 1'b0;
        fft_sink_ready = 1'b0;
        clear_overflow = 1'b0;
        in_i = '0;
        in_q = '0;
        tick();
        reset_reset_n = 1'b1;
        mq.delete();
        mpos = 0;
        mframes = 0;
        movf = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset_n  = 1'b0;
        in_valid       = 1'b1;
        fft_sink_ready = 1'b1;
        clear_overflow = 1'b0;
        in_i = 22'h155555;
        in_q = 22'h2AAAAA;
        tick();
        tick();
        checks++; if (fft_sink_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fft_sink_valid); end
        checks++; if (fft_sink_startofpacket !== 1'b0) begin failures++; $display("FAIL reset_sop got=%b exp=0", fft_sink_startofpacket); end
        checks++; if (fft_sink_endofpacket !== 1'b0) begin failures++; $display("FAIL reset_eop got=%b exp=0", fft_sink_endofpacket); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frames got=%0d exp=0", frame_count); end
        checks++; if (fft_sink_data !== 44'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", fft_sink_data); end
        checks++; if (fft_sink_error !== 2'b00) begin failures++; $display("FAIL error_const got=%b exp=00", fft_sink_error); end
        apply_reset();
    endtask

    task automatic test_stream();
        int n = 0, sops = 0, eops = 0;
        logic [43:0] w;
        apply_reset();
        fft_sink_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_valid = (k < 17);
            in_i = 22'(k);
            in_q = 22'(-k);
            checks++; if (fft_sink_valid !== (mq.size() != 0)) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", k, fft_sink_valid, mq.size() != 0); end
            if (fft_sink_valid === 1'b1) begin
                w = {22'(n), 22'(-n)};
                checks++; if (fft_sink_data !== w) begin failures++; $display("FAIL stream_data n=%0d got=%h exp=%h", n, fft_sink_data, w); end
                checks++; if (fft_sink_startofpacket !== (n % LEN == 0)) begin failures++; $display("FAIL stream_sop n=%0d got=%b", n, fft_sink_startofpacket); end
                checks++; if (fft_sink_endofpacket !== (n % LEN == LEN - 1)) begin failures++; $display("FAIL stream_eop n=%0d got=%b", n, fft_sink_endofpacket); end
                if (fft_sink_startofpacket === 1'b1) sops++;
                if (fft_sink_endofpacket === 1'b1) eops++;
                n++;
            end
            model_step();
            tick();
        end
        checks++; if (n != 17) begin failures++; $display("FAIL stream_count got=%0d exp=17", n); end
        checks++; if (sops != 3 || eops != 2) begin failures++; $display("FAIL stream_markers sop=%0d eop=%0d exp=3/2", sops, eops); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL stream_frames got=%0d exp=2", frame_count); end
    endtask

    task automatic test_overflow();
        int n = 0;
        apply_reset();
        fft_sink_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            in_valid = (k < 20);
            fft_sink_ready = (k >= 20);
            in_i = 22'($urandom);
            in_q = 22'($urandom);
            checks++; if (fft_sink_valid !== (mq.size() != 0)) begin failures++; $display("FAIL ovf_valid cyc=%0d got=%b", k, fft_sink_valid); end
            if (mq.size() != 0) begin
                checks++; if (fft_sink_data !== mq[0]) begin failures++; $display("FAIL ovf_data cyc=%0d got=%h exp=%h", k, fft_sink_data, mq[0]); end
                checks++; if (fft_sink_startofpacket !== (mpos == 0) || fft_sink_endofpacket !== (mpos == LEN - 1)) begin failures++; $display("FAIL ovf_marks cyc=%0d sop=%b eop=%b pos=%0d", k, fft_sink_startofpacket, fft_sink_endofpacket, mpos); end
            end
            if (fft_sink_valid === 1'b1 && fft_sink_ready === 1'b1) n++;
            if (k == 20) begin
                checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
            end
            model_step();
            tick();
        end
        checks++; if (n != DEPTH) begin failures++; $display("FAIL ovf_drained got=%0d exp=%0d", n, DEPTH); end
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL ovf_frames got=%0d exp=2", frame_count); end
    endtask

    task automatic test_overflow_clear();
        fft_sink_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            in_valid = 1'b1;
            in_i = 22'($urandom);
            in_q = 22'($urandom);
            model_step();
            tick();
        end
        clear_overflow = 1'b1;
        in_valid = 1'b1;
        model_step();
        tick();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_vs_drop got=%b exp=1", overflow); end
        in_valid = 1'b0;
        model_step();
        tick();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clr_alone got=%b exp=0", overflow); end
        clear_overflow = 1'b0;
        checks++; if (fft_sink_data !== mq[0]) begin failures++; $display("FAIL clr_head got=%h exp=%h", fft_sink_data, mq[0]); end
    endtask

    task automatic test_toggle();
        logic pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0;
        logic [43:0] pd = '0;
        apply_reset();
        for (int k = 0; k < 48; k++) begin
            in_valid = (k % 2 == 0);
            fft_sink_ready = (k % 2 == 0);
            in_i = 22'($urandom);
            in_q = 22'($urandom);
            checks++; if (fft_sink_valid !== (mq.size() != 0)) begin failures++; $display("FAIL tog_valid cyc=%0d got=%b", k, fft_sink_valid); end
            if (mq.size() != 0) begin
                checks++; if (fft_sink_data !== mq[0] || fft_sink_startofpacket !== (mpos == 0) || fft_sink_endofpacket !== (mpos == LEN - 1)) begin failures++; $display("FAIL tog_word cyc=%0d got=%h exp=%h", k, fft_sink_data, mq[0]); end
            end
            if (pv && !pr) begin
                checks++; if (fft_sink_data !== pd || fft_sink_startofpacket !== ps || fft_sink_endofpacket !== pe) begin failures++; $display("FAIL tog_hold cyc=%0d got=%h exp=%h", k, fft_sink_data, pd); end
            end
            pv = fft_sink_valid; pr = fft_sink_ready; pd = fft_sink_data;
            ps = fft_sink_startofpacket; pe = fft_sink_endofpacket;
            model_step();
            tick();
        end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL tog_ovf got=%b exp=0", overflow); end
        checks++; if (frame_count !== 16'(mframes)) begin failures++; $display("FAIL tog_frames got=%0d exp=%0d", frame_count, mframes); end
    endtask

    task automatic test_full_rw();
        int n = 0;
        apply_reset();
        for (int k = 0; k < DEPTH + 5 + 20; k++) begin
            in_valid = (k < DEPTH + 5);
            fft_sink_ready = (k >= DEPTH);
            in_i = 22'($urandom);
            in_q = 22'($urandom);
            if (mq.size() != 0) begin
                checks++; if (fft_sink_valid !== 1'b1 || fft_sink_data !== mq[0]) begin failures++; $display("FAIL full_word cyc=%0d got=%h exp=%h", k, fft_sink_data, mq[0]); end
            end
            if (k >= DEPTH + 5 && fft_sink_valid === 1'b1) n++;
            model_step();
            tick();
        end
        checks++; if (n != DEPTH) begin failures++; $display("FAIL full_occupancy got=%0d exp=%0d", n, DEPTH); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_ovf got=%b exp=0", overflow); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fft_sink_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_i = 22'($urandom);
            in_q = 22'($urandom);
            model_step();
            tick();
        end
        checks++; if (fft_sink_valid !== 1'b1 || fft_sink_startofpacket !== 1'b0) begin failures++; $display("FAIL mid_pre valid=%b sop=%b pos=%0d", fft_sink_valid, fft_sink_startofpacket, mpos); end
        reset_reset_n = 1'b0;
        tick();
        reset_reset_n = 1'b1;
        in_valid = 1'b0;
        mq.delete(); mpos = 0; mframes = 0; movf = 1'b0;
        checks++; if (fft_sink_valid !== 1'b0) begin failures++; $display("FAIL mid_flush got=%b exp=0", fft_sink_valid); end
        in_valid = 1'b1;
        in_i = 22'h0ABCDE;
        in_q = 22'h3F0F0F;
        fft_sink_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++; if (fft_sink_valid !== 1'b1 || fft_sink_startofpacket !== 1'b1) begin failures++; $display("FAIL mid_sop valid=%b sop=%b exp=1/1", fft_sink_valid, fft_sink_startofpacket); end
        checks++; if (fft_sink_data !== {22'h0ABCDE, 22'h3F0F0F}) begin failures++; $display("FAIL mid_data got=%h", fft_sink_data); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL mid_frames got=%0d exp=0", frame_count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_overflow_clear();
        test_toggle();
        test_full_rw();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_feeder.md
# fft_frame_feeder

Upstream feeder for the FM FFT subsystem. Accepts a free-running stream of complex baseband samples from the FM down-converter, buffers them in a small FIFO, and presents them to the FFT II sink as an Avalon-ST stream framed into packets of FFT_LEN samples with start-of-packet and end-of-packet markers. Backpressure from the FFT is absorbed by the FIFO. Overflow is flagged, never silent.

## Interface
Parameters:
- FFT_LEN, 1024, samples per FFT frame; power of 2, 8..65536.
- DATA_W, 22, width of each I and Q component; fixed so that 2*DATA_W = 44.
- FIFO_DEPTH, 16, buffer entries; power of 2, at least 4.

Ports:
- clk_clk  input  1  single system clock.
- reset_reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  one sample per cycle when high; no backpressure upstream.
- in_i  input  DATA_W  in-phase sample, two's complement.
- in_q  input  DATA_W  quadrature sample, two's complement.
- fft_sink_valid  output  1  stream word valid.
- fft_sink_ready  input  1  FFT accepts the word; ready latency 0.
- fft_sink_error  output  2  constant 2'b00.
- fft_sink_startofpacket  output  1  first sample of a frame.
- fft_sink_endofpacket  output  1  last sample of a frame.
- fft_sink_data  output  44  {in_i, in_q}; real part in [43:22], imaginary part in [21:0].
- overflow  output  1  sticky flag; set when a sample is dropped.
- clear_overflow  input  1  synchronous clear of overflow.
- frame_count  output  16  number of completed frames (eop transfers); wraps modulo 2^16.

## Operation
- Write: push {in_i, in_q} when in_valid is high and the FIFO is not full.
  - If the FIFO is full and a read transfer occurs in the same cycle, the push is still accepted, so no drop occurs.
- Drop: in_valid high, FIFO full, and no read that cycle.
  - The sample is discarded and overflow is set on the next edge.
  - Frame indexing is unaffected: the dropped sample is simply absent.
- Read: the FIFO is show-ahead. fft_sink_valid = FIFO not empty. fft_sink_data = FIFO head.
- Transfer: a word transfers on a cycle where fft_sink_valid and fft_sink_ready are both high. Each transfer pops the FIFO and advances the index counter idx.
- idx runs 0..FFT_LEN-1 and wraps to 0 after the transfer at FFT_LEN-1.
- fft_sink_startofpacket = (idx == 0) & fft_sink_valid.
- fft_sink_endofpacket = (idx == FFT_LEN-1) & fft_sink_valid.
- frame_count increments on each eop transfer.
- overflow:
  - Set has priority over clear_overflow in the same cycle.
  - Otherwise clear_overflow drives it to 0.
- There is no arithmetic on the samples; they pass through bit-exact.

## Timing
- Reset values (synchronous, active-low): FIFO empty, fft_sink_valid 0, idx 0, fft_sink_startofpacket 0, fft_sink_endofpacket 0, overflow 0, frame_count 0, fft_sink_data don't-care (implementation drives 0).
- Latency: a sample written at edge N into an empty FIFO appears with fft_sink_valid high after edge N, i.e. one cycle of latency.
- fft_sink_valid depends only on registered state, never on fft_sink_ready.
- While valid is high and ready is low, data, sop and eop hold stable.
- Reset mid-frame:
  - The FIFO is flushed and idx returns to 0.
  - The first word after reset carries sop.
  - The partially sent frame is abandoned. The FFT core is reset by the same reset_reset_n.
- Full FIFO with a simultaneous read and write: occupancy is unchanged and no drop occurs.
- Empty FIFO with a write and no read: the word becomes visible the next cycle. No write-through in the same cycle.
- frame_count wraps from 16'hFFFF to 0.

## Structure
- Shared package fm_fft_pkg holds:
  - DATA_W, FFT_LEN and SINK_W = 44 constants.
  - Field offsets for the real and imaginary parts.
  - Avalon-ST error code constants; 2'b00 is used here.
- Sub-module fft_feed_fifo: synchronous show-ahead FIFO, parameterised on width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Occupancy counter of log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop are legal when full.
- The top level holds idx, the sop/eop decode, the overflow logic and frame_count.

## Test plan
- Continuous in_valid and ready held high, FFT_LEN=8 → sop on samples 0, 8 and 16, eop on samples 7 and 15, frame_count=2 after 16 transfers, data bit-exact ({in_i, in_q} with in_i=i, in_q=-i).
- Ready held low for 20 cycles with in_valid high, FIFO_DEPTH=16 → 16 samples accepted, 4 dropped, overflow=1. Once ready is released, 16 words drain in order with the index continuing.
- Ready toggled 1010… with in_valid on every other cycle → no drop, fft_sink_data/sop/eop stable whenever valid is high and ready is low, overflow=0.
- FIFO full, then in_valid and ready both high for 5 cycles → occupancy stays at 16 and overflow stays 0.
- reset_reset_n low for one cycle at idx=5 (FFT_LEN=8) → next edge shows valid=0 and empty FIFO. The next accepted sample emerges with sop=1 and frame_count=0.
- overflow set, then clear_overflow asserted in the same cycle as a new drop → overflow stays 1. clear_overflow asserted alone → overflow goes to 0.
